// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS unified-memory arbiter.
//   state_e : arbiter FSM states
//   owner_e : which port owns the outstanding read
//   MEM_LAT_MAX / CNT_W : largest supported read latency and latency counter width
package mips_mem_pkg;

  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic {IDLE, RD_WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the fetch port, the load/store port, the arbiter and the
// memory macro.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants/data/strobes)
//   master : environment view (fetch/load-store requesters plus memory macro)
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_mem_arb_pick.sv
// Combinational winner selection between fetch (IF) and load/store (DM).
//   if_req_i, dm_req_i : qualified requests (already gated to grantable cycles)
//   rr_ptr_i           : 0 favours DM on contention, 1 favours IF
//   win_if_o, win_dm_o : one-hot (or zero) winner
module mips_mem_arb_pick (
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic rr_ptr_i,
  output logic win_if_o,
  output logic win_dm_o
);

  assign win_dm_o = dm_req_i & (~if_req_i | ~rr_ptr_i);
  assign win_if_o = if_req_i & (~dm_req_i |  rr_ptr_i);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter for the single-port unified I/D memory of the MIPS core. One access
// outstanding at a time; reads wait MEM_LAT cycles for data, stores complete
// in the grant cycle.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : mips_mem_arbiter_if.slave (IF port, DM port, memory macro)
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..7).
// Build option: MIPS_MEM_ARB_RR_EN selects round-robin on contention;
// without it DM always beats IF.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  mips_mem_arbiter_if.slave bus
);

  state_e            state_q;
  owner_e            own_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  logic idle, win_if, win_dm, rd_start, rd_done, rr_ptr;

  // Grants are only possible in IDLE and never while reset is held.
  assign idle = (state_q == IDLE) && !rst;

  mips_mem_arb_pick u_pick (
    .if_req_i (bus.if_req & idle),
    .dm_req_i (bus.dm_req & idle),
    .rr_ptr_i (rr_ptr),
    .win_if_o (win_if),
    .win_dm_o (win_dm)
  );

`ifdef MIPS_MEM_ARB_RR_EN
  logic rr_q;
  // After a contested grant favour the port that just lost.
  always_ff @(posedge clk) begin
    if (rst)                                   rr_q <= 1'b0;
    else if (idle && bus.if_req && bus.dm_req) rr_q <= win_dm;
  end
  assign rr_ptr = rr_q;
`else
  assign rr_ptr = 1'b0;
`endif

  assign rd_start = win_if | (win_dm & ~bus.dm_we);
  // Counter was loaded with MEM_LAT at grant; the cycle it steps 1->0 is the
  // data cycle, i.e. exactly MEM_LAT cycles after the grant.
  assign rd_done  = (state_q == RD_WAIT) && (cnt_q == CNT_W'(1)) && !rst;

  assign bus.if_gnt    = win_if;
  assign bus.dm_gnt    = win_dm;
  assign bus.mem_en    = win_if | win_dm;
  assign bus.mem_we    = win_dm & bus.dm_we;
  assign bus.mem_addr  = win_dm ? bus.dm_addr : (win_if ? bus.if_addr : '0);
  assign bus.mem_wdata = win_dm ? bus.dm_wdata : '0;

  assign bus.if_rvalid = rd_done && (own_q == OWN_IF);
  assign bus.dm_rvalid = rd_done && (own_q == OWN_DM);
  // Pass memory data straight through on the valid cycle, otherwise hold.
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : if_rdata_q;
  assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : dm_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      own_q      <= OWN_IF;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_start) begin
            cnt_q   <= CNT_W'(MEM_LAT);
            own_q   <= win_if ? OWN_IF : OWN_DM;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            if (own_q == OWN_IF) if_rdata_q <= bus.mem_rdata;
            else                 dm_rdata_q <= bus.mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
module tb_mips_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_mem_arbiter_if b ();
  mips_mem_arbiter_if b1 ();
  mips_mem_arbiter_if b7 ();

  mips_mem_arbiter #(.MEM_LAT(2)) dut   (.clk(clk), .rst(rst), .bus(b.slave));
  mips_mem_arbiter #(.MEM_LAT(1)) u_l1  (.clk(clk), .rst(rst), .bus(b1.slave));
  mips_mem_arbiter #(.MEM_LAT(7)) u_l7  (.clk(clk), .rst(rst), .bus(b7.slave));

  // Memory models: word array for the main DUT, address-pattern data for the
  // latency sweep DUTs. Each is a read pipeline of depth MEM_LAT.
  logic [31:0] mem [256];
  logic [31:0] p2 [8];
  logic [31:0] p1 [8];
  logic [31:0] p7 [8];

  always @(posedge clk) begin
    if (rst) begin
      mem[16] <= 32'h2008_0005;
      mem[17] <= 32'h3333_4444;
      mem[18] <= 32'h1111_2222;
    end else if (b.mem_en && b.mem_we) begin
      mem[b.mem_addr[9:2]] <= b.mem_wdata;
    end
    p2[0] <= (b.mem_en  && !b.mem_we)  ? mem[b.mem_addr[9:2]] : 32'h0;
    p1[0] <= (b1.mem_en && !b1.mem_we) ? ~b1.mem_addr : 32'h0;
    p7[0] <= (b7.mem_en && !b7.mem_we) ? ~b7.mem_addr : 32'h0;
    for (int i = 1; i < 8; i++) begin
      p2[i] <= p2[i-1];
      p1[i] <= p1[i-1];
      p7[i] <= p7[i-1];
    end
  end
  assign b.mem_rdata  = p2[1];
  assign b1.mem_rdata = p1[0];
  assign b7.mem_rdata = p7[6];

  // Requesters must hold request and payload until granted.
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (b.if_req && !b.if_gnt) |=> (b.if_req && $stable(b.if_addr)))
    else $error("protocol violation: if_req dropped or changed before grant");
  a_dm_hold: assert property (@(posedge clk) disable iff (rst)
    (b.dm_req && !b.dm_gnt) |=> (b.dm_req && $stable({b.dm_we, b.dm_addr, b.dm_wdata})))
    else $error("protocol violation: dm_req dropped or changed before grant");

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        dmr, dmwe;
    logic [31:0] dma, dmwd;
    logic [5:0]  flg;   // {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we}
    logic [31:0] maddr, mwd, ird, drd;
  } vec_t;

  function automatic vec_t mk(logic ifr, logic [31:0] ifa, logic dmr, logic dmwe,
                              logic [31:0] dma, logic [31:0] dmwd, logic [5:0] flg,
                              logic [31:0] maddr, logic [31:0] mwd,
                              logic [31:0] ird, logic [31:0] drd);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dmwe = dmwe; v.dma = dma; v.dmwd = dmwd;
    v.flg = flg; v.maddr = maddr; v.mwd = mwd; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  function automatic logic [191:0] got_main();
    return {58'b0, b.if_gnt, b.dm_gnt, b.if_rvalid, b.dm_rvalid, b.mem_en, b.mem_we,
            b.mem_en ? b.mem_addr : 32'h0, (b.mem_en && b.mem_we) ? b.mem_wdata : 32'h0,
            b.if_rdata, b.dm_rdata};
  endfunction

  task automatic drive(input logic ifr, input logic [31:0] ifa, input logic dmr,
                       input logic dmwe, input logic [31:0] dma, input logic [31:0] dmwd);
    b.if_req = ifr; b.if_addr = ifa;
    b.dm_req = dmr; b.dm_we = dmwe; b.dm_addr = dma; b.dm_wdata = dmwd;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  localparam logic [31:0] I1 = 32'h2008_0005, I2 = 32'h3333_4444, D1 = 32'h1111_2222;
  localparam logic [31:0] DB = 32'hDEAD_BEEF, BF = 32'h0BAD_F00D, W2 = 32'h1234_5678;

  vec_t tv [22];

  initial begin
    int order [6];
    int exp_o [6];
    int ng, cyc;
    logic gi, gd;
    int g1 [2], g7 [2];
    int r1, r7, n1, n7;
    logic [31:0] d1, d7;
    logic drop1, drop7;

    tv[0]  = mk(0, 0,      0, 0, 0,      0,  6'b000000, 0,      0,  0,  0);
    tv[1]  = mk(1, 'h40,   0, 0, 0,      0,  6'b100010, 'h40,   0,  0,  0);
    tv[2]  = mk(0, 0,      0, 0, 0,      0,  6'b000000, 0,      0,  0,  0);
    tv[3]  = mk(0, 0,      0, 0, 0,      0,  6'b001000, 0,      0,  I1, 0);
    tv[4]  = mk(1, 'h44,   1, 0, 'h48,   0,  6'b010010, 'h48,   0,  I1, 0);
    tv[5]  = mk(1, 'h44,   0, 0, 0,      0,  6'b000000, 0,      0,  I1, 0);
    tv[6]  = mk(1, 'h44,   0, 0, 0,      0,  6'b000100, 0,      0,  I1, D1);
    tv[7]  = mk(1, 'h44,   0, 0, 0,      0,  6'b100010, 'h44,   0,  I1, D1);
    tv[8]  = mk(0, 0,      0, 0, 0,      0,  6'b000000, 0,      0,  I1, D1);
    tv[9]  = mk(0, 0,      0, 0, 0,      0,  6'b001000, 0,      0,  I2, D1);
    tv[10] = mk(0, 0,      1, 1, 'h100,  DB, 6'b010011, 'h100,  DB, I2, D1);
    tv[11] = mk(0, 0,      1, 0, 'h100,  0,  6'b010010, 'h100,  0,  I2, D1);
    tv[12] = mk(0, 0,      0, 0, 0,      0,  6'b000000, 0,      0,  I2, D1);
    tv[13] = mk(0, 0,      0, 0, 0,      0,  6'b000100, 0,      0,  I2, DB);
    tv[14] = mk(0, 0,      1, 1, 'h104,  BF, 6'b010011, 'h104,  BF, I2, DB);
    tv[15] = mk(0, 0,      1, 1, 'h108,  W2, 6'b010011, 'h108,  W2, I2, DB);
    tv[16] = mk(0, 0,      1, 0, 'h104,  0,  6'b010010, 'h104,  0,  I2, DB);
    tv[17] = mk(0, 0,      0, 0, 0,      0,  6'b000000, 0,      0,  I2, DB);
    tv[18] = mk(0, 0,      0, 0, 0,      0,  6'b000100, 0,      0,  I2, BF);
    tv[19] = mk(1, 'h108,  0, 0, 0,      0,  6'b100010, 'h108,  0,  I2, BF);
    tv[20] = mk(0, 0,      0, 0, 0,      0,  6'b000000, 0,      0,  I2, BF);
    tv[21] = mk(0, 0,      0, 0, 0,      0,  6'b001000, 0,      0,  W2, BF);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
    b7.if_req = 0; b7.if_addr = 0; b7.dm_req = 0; b7.dm_we = 0; b7.dm_addr = 0; b7.dm_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", got_main(), 192'h0);

    // Directed cycle table on the MEM_LAT=2 instance.
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      drive(tv[i].ifr, tv[i].ifa, tv[i].dmr, tv[i].dmwe, tv[i].dma, tv[i].dmwd);
      @(negedge clk);
      chk($sformatf("row%0d", i), got_main(),
          {58'b0, tv[i].flg, tv[i].maddr, tv[i].mwd, tv[i].ird, tv[i].drd});
    end

    // Reset during an outstanding fetch read.
    @(posedge clk); #1 drive(1, 32'h40, 0, 0, 0, 0);
    @(negedge clk); chk("abort_gnt", 192'(b.if_gnt), 192'(1));
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0); rst = 1'b1;
    @(negedge clk); chk("abort_in_rst", {b.if_gnt, b.dm_gnt, b.if_rvalid, b.mem_en}, 192'h0);
    @(posedge clk); #1 rst = 1'b0; drive(0, 0, 1, 0, 32'h48, 0);
    @(negedge clk); chk("post_rst_gnt", {b.dm_gnt, b.if_rvalid, b.if_rdata, b.dm_rdata},
                        {1'b1, 1'b0, 32'h0, 32'h0});
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("abort_no_rvalid%0d", k), 192'(b.if_rvalid), 192'(0));
      if (k == 2) chk("post_rst_load", {b.dm_rvalid, b.dm_rdata}, {1'b1, D1});
    end

    // Continuous contention: grant order depends on the arbitration build.
`ifdef MIPS_MEM_ARB_RR_EN
    exp_o = '{1, 0, 1, 0, 1, 0};
`else
    exp_o = '{1, 1, 1, 1, 1, 1};
`endif
    pulse_rst();
    @(posedge clk); #1 drive(1, 32'h40, 1, 0, 32'h44, 0);
    ng = 0; cyc = 0;
    order = '{-1, -1, -1, -1, -1, -1};
    while ((b.if_req || b.dm_req) && cyc < 200) begin
      @(negedge clk);
      gi = b.if_gnt; gd = b.dm_gnt;
      if (gi && gd) chk("one_hot_gnt", {gi, gd}, 192'b10);
      if ((gi || gd) && ng < 6) begin order[ng] = gd ? 1 : 0; ng++; end
      @(posedge clk); #1;
      if (ng >= 6) begin
        if (gi) b.if_req = 1'b0;
        if (gd) b.dm_req = 1'b0;
      end
      cyc++;
    end
    chk("contend_bound", 192'(cyc < 200), 192'(1));
    for (int k = 0; k < 6; k++)
      chk($sformatf("contend_order%0d", k), 192'(order[k]), 192'(exp_o[k]));
    repeat (4) @(posedge clk);

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=7 instances.
    g1 = '{0, 0}; g7 = '{0, 0}; r1 = -1; r7 = -1; n1 = 0; n7 = 0; d1 = 0; d7 = 0;
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 32'h20;
    b7.if_req = 1; b7.if_addr = 32'h20;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      drop1 = 1'b0; drop7 = 1'b0;
      if (b1.if_gnt && n1 < 2) begin g1[n1] = c; n1++; drop1 = (n1 == 2); end
      if (b7.if_gnt && n7 < 2) begin g7[n7] = c; n7++; drop7 = (n7 == 2); end
      if (b1.if_rvalid && r1 < 0) begin r1 = c; d1 = b1.if_rdata; end
      if (b7.if_rvalid && r7 < 0) begin r7 = c; d7 = b7.if_rdata; end
      @(posedge clk); #1;
      if (drop1) b1.if_req = 1'b0;
      if (drop7) b7.if_req = 1'b0;
    end
    chk("lat1_rvalid", 192'(r1 - g1[0]), 192'(1));
    chk("lat1_thru",   192'(g1[1] - g1[0]), 192'(2));
    chk("lat1_data",   192'(d1), 192'(32'hFFFF_FFDF));
    chk("lat7_rvalid", 192'(r7 - g7[0]), 192'(7));
    chk("lat7_thru",   192'(g7[1] - g7[0]), 192'(8));
    chk("lat7_data",   192'(d7), 192'(32'hFFFF_FFDF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Arbitrates the single-port unified instruction/data memory of the 32-bit MIPS core between the instruction-fetch port (IF) and the load/store port (DM). It sequences each access through a small state machine, hides the memory's fixed read latency behind a grant/valid handshake, and keeps one access outstanding at a time. It sits between the MIPS pipeline's fetch and memory stages and the memory macro.

## Interface
Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits
- MEM_LAT, 2, cycles from `mem_en` (read) to valid `mem_rdata`; legal range 1..7

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request, level; held until `if_gnt`
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch issued to memory
- if_rvalid  out  1  one-cycle pulse: `if_rdata` valid
- if_rdata  out  DATA_W  fetch data
- dm_req  in  1  load/store request, level; held until `dm_gnt`
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  load/store address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle pulse: load/store issued
- dm_rvalid  out  1  one-cycle pulse: `dm_rdata` valid (loads only)
- dm_rdata  out  DATA_W  load data
- mem_en, mem_we  out  1  memory strobe / write enable
- mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, RD_WAIT.
- IDLE: if any request, pick a winner (see Configuration), drive `mem_en`, `mem_addr`, `mem_we`, and `mem_wdata` combinationally from the winner, and pulse its `*_gnt`.
  - Read: load the latency counter with MEM_LAT, latch the owner (IF/DM), go to RD_WAIT.
  - Store: stay in IDLE; no rvalid.
- RD_WAIT: count down. When the counter reaches 0, pulse the owner's `*_rvalid` with `*_rdata = mem_rdata`, then go to IDLE. No `mem_en` and no grant while in RD_WAIT.
- The non-owner `*_rdata` holds its last value. The IF port never writes: `mem_we = 0` whenever IF wins.
- Requesters must hold `req`, `addr`, `we`, and `wdata` stable until granted. Dropping a request before grant is a protocol violation and must be flagged by a bench assertion.

## Timing
- Grant latency: same cycle as `req` when in IDLE (combinational).
- Read granted at cycle T: `rvalid` at T+MEM_LAT. Earliest next grant is T+MEM_LAT+1.
- Store granted at T: earliest next grant is T+1, so back-to-back stores run one per cycle.
- Simultaneous `if_req` and `dm_req` in IDLE: exactly one grant. The loser keeps its request and is granted at the next IDLE cycle.
- Reset values: state IDLE, counter 0, all `*_gnt`, `*_rvalid`, `mem_en`, and `mem_we` = 0, `*_rdata` = 0, RR pointer favours DM.
- Reset during RD_WAIT aborts the read: no `rvalid` is ever produced for it, and the first post-reset grant is possible in the cycle after `rst` deasserts.
- The counter is 3 bits wide and never wraps: it is loaded only in IDLE.

## Configuration
- `MIPS_MEM_ARB_RR_EN` defined: round-robin arbitration. A 1-bit pointer flips to the other port after each contested grant, so under continuous contention the grants alternate DM, IF, DM, …
- Not defined: fixed priority, DM always over IF, which lets the older instruction win. The pointer flop is not instantiated.

## Structure
- Package `mips_mem_pkg`:
  - state enum (IDLE, RD_WAIT)
  - owner enum (OWN_IF, OWN_DM)
  - `MEM_LAT_MAX = 7`
  - counter width constant
- Sub-module `mips_mem_arb_pick`: combinational winner selection from `if_req`, `dm_req`, and the RR pointer. The pointer input is tied to 0 when the macro is off.

## Test plan
- MEM_LAT=2, IF read of 0x0000_0040 at T, memory returns 0x2008_0005 → `if_gnt` at T, `if_rvalid` with 0x2008_0005 at T+2, no grant at T+1 or T+2.
- Both ports request reads at T, fixed priority → `dm_gnt` at T, `dm_rvalid` at T+2, `if_gnt` at T+3.
- DM store of 0xDEAD_BEEF to 0x100 at T, then DM load of 0x100 at T+1 → `mem_we` = 1 at T, `dm_gnt` at T+1, `dm_rdata` = 0xDEAD_BEEF at T+3, no `dm_rvalid` for the store.
- `MIPS_MEM_ARB_RR_EN`, both ports issuing continuous reads for 6 grants → grant order DM, IF, DM, IF, DM, IF.
- `rst` asserted at T+1 after an IF read grant at T → no `if_rvalid` ever, outputs 0; a new request at the first non-reset cycle is granted that cycle.
- MEM_LAT=1 and MEM_LAT=7 sweeps → `rvalid` exactly MEM_LAT cycles after grant; throughput is one read per MEM_LAT+1 cycles.
